// File: rtl/rd53_afe_to_cal_pkg.sv
// rtl/rd53_afe_to_cal_pkg.sv - shared state encoding and latch-decode constants for the AFE calibration sequencer
package rd53_afe_to_cal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AZ,
        ST_INJ,
        ST_WAIT,
        ST_STROBE,
        ST_GAP,
        ST_FIN
    } cal_state_e;

    localparam logic [1:0] LATCH_HIT   = 2'b01;
    localparam logic [1:0] LATCH_NOHIT = 2'b10;

    // Width of the per-phase cycle counter; every phase length must fit in it.
    localparam int CYC_W = 8;

endpackage

// File: rtl/rd53_sat_cnt.sv
// rtl/rd53_sat_cnt.sv - up-counter that clears on request and sticks at all-ones
module rd53_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rd53_afe_to_cal_seq.sv
// rtl/rd53_afe_to_cal_seq.sv - AFE charge-injection calibration sequencer; AZ phase enabled by AFE_TO_CAL_AZ_EN
module rd53_afe_to_cal_seq
    import rd53_afe_to_cal_pkg::*;
#(
    parameter int N_W     = 8,
    parameter int CNT_W   = 8,
    parameter int AZ_CYC  = 4,
    parameter int INJ_CYC = 2,
    parameter int STB_DLY = 3,
    parameter int STB_CYC = 2,
    parameter int GAP_CYC = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic [N_W-1:0]   N_INJ,
    input  logic             SEL_S1,
    input  logic             VOUTP_TO,
    input  logic             VOUTN_TO,
    output logic             S0,
    output logic             S1,
    output logic             PHI_AZ_TO,
    output logic             STROBE_TO,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] HIT_CNT,
    output logic [CNT_W-1:0] ERR_CNT
);

    cal_state_e       state;
    logic [CYC_W-1:0] cyc;
    logic [CYC_W-1:0] cyc_len;
    logic             cyc_last;
    logic [N_W-1:0]   rem;
    logic             sel_s1_q;
    logic             s0_q;
    logic             s1_q;
    logic             stb_q;
    logic             busy_q;
    logic             done_q;
`ifdef AFE_TO_CAL_AZ_EN
    logic             phi_q;
`endif
    logic [1:0]       latch;
    logic             accept;
    logic             sample;
    logic             hit_inc;
    logic             err_inc;

    always_comb begin
        case (state)
            ST_AZ:     cyc_len = CYC_W'(AZ_CYC);
            ST_INJ:    cyc_len = CYC_W'(INJ_CYC);
            ST_WAIT:   cyc_len = CYC_W'(STB_DLY);
            ST_STROBE: cyc_len = CYC_W'(STB_CYC);
            ST_GAP:    cyc_len = CYC_W'(GAP_CYC);
            default:   cyc_len = CYC_W'(1);
        endcase
        cyc_last = (cyc == cyc_len - 1'b1);
        latch    = {VOUTP_TO, VOUTN_TO};
        accept   = (state == ST_IDLE) && START;
        // An abort on the final strobe cycle wins, so that injection is not scored.
        sample   = (state == ST_STROBE) && cyc_last && !ABORT;
        hit_inc  = sample && (latch == LATCH_HIT);
        err_inc  = sample && (latch != LATCH_HIT) && (latch != LATCH_NOHIT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            cyc      <= '0;
            rem      <= '0;
            sel_s1_q <= 1'b0;
            s0_q     <= 1'b0;
            s1_q     <= 1'b0;
            stb_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef AFE_TO_CAL_AZ_EN
            phi_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            cyc    <= cyc_last ? '0 : cyc + 1'b1;
            if (ABORT && (state != ST_IDLE) && (state != ST_FIN)) begin
                state <= ST_FIN;
                cyc   <= '0;
                s0_q  <= 1'b0;
                s1_q  <= 1'b0;
                stb_q <= 1'b0;
`ifdef AFE_TO_CAL_AZ_EN
                phi_q <= 1'b0;
`endif
            end else begin
                case (state)
                    ST_IDLE: if (START) begin
                        busy_q   <= 1'b1;
                        rem      <= N_INJ;
                        sel_s1_q <= SEL_S1;
                        cyc      <= '0;
                        if (N_INJ == '0) begin
                            state <= ST_FIN;
                        end else begin
`ifdef AFE_TO_CAL_AZ_EN
                            state <= ST_AZ;
                            phi_q <= 1'b1;
`else
                            state <= ST_INJ;
                            s0_q  <= !SEL_S1;
                            s1_q  <= SEL_S1;
`endif
                        end
                    end
`ifdef AFE_TO_CAL_AZ_EN
                    ST_AZ: if (cyc_last) begin
                        phi_q <= 1'b0;
                        s0_q  <= !sel_s1_q;
                        s1_q  <= sel_s1_q;
                        state <= ST_INJ;
                    end
`endif
                    ST_INJ: if (cyc_last) begin
                        s0_q  <= 1'b0;
                        s1_q  <= 1'b0;
                        state <= ST_WAIT;
                    end
                    ST_WAIT: if (cyc_last) begin
                        stb_q <= 1'b1;
                        state <= ST_STROBE;
                    end
                    ST_STROBE: if (cyc_last) begin
                        stb_q <= 1'b0;
                        rem   <= rem - 1'b1;
                        state <= ST_GAP;
                    end
                    ST_GAP: if (cyc_last) begin
                        if (rem != '0) begin
`ifdef AFE_TO_CAL_AZ_EN
                            state <= ST_AZ;
                            phi_q <= 1'b1;
`else
                            state <= ST_INJ;
                            s0_q  <= !sel_s1_q;
                            s1_q  <= sel_s1_q;
`endif
                        end else begin
                            state <= ST_FIN;
                        end
                    end
                    ST_FIN: begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    rd53_sat_cnt #(.W(CNT_W)) u_hit_cnt (
        .clk (CLK),
        .rst (RST),
        .clr (accept),
        .inc (hit_inc),
        .cnt (HIT_CNT)
    );

    rd53_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk (CLK),
        .rst (RST),
        .clr (accept),
        .inc (err_inc),
        .cnt (ERR_CNT)
    );

    assign S0        = s0_q;
    assign S1        = s1_q;
    assign STROBE_TO = stb_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
`ifdef AFE_TO_CAL_AZ_EN
    assign PHI_AZ_TO = phi_q;
`else
    assign PHI_AZ_TO = 1'b0;
`endif

endmodule
